// File: rtl/mem_access_stage_pkg.sv
// Shared widths, FSM encoding and defaults for the memory-access pipeline stage.
package mem_access_stage_pkg;

  localparam int WORD_WIDTH      = 32;
  localparam int REG_SIZE        = 5;
  localparam logic [WORD_WIDTH-1:0] ZERO_WORD = '0;
  localparam int DEFAULT_TIMEOUT = 16;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: loads a new writeback or inserts a bubble that
// clears the write enable while holding destination and result.
module mem_wb_reg
  import mem_access_stage_pkg::*;
#(
  parameter int WORD_W = WORD_WIDTH,
  parameter int REG_W  = REG_SIZE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              we_i,
  input  logic [REG_W-1:0]  dest_i,
  input  logic [WORD_W-1:0] result_i,
  input  logic              align_err_i,
  input  logic              bus_err_i,
  output logic              we_o,
  output logic [REG_W-1:0]  dest_o,
  output logic [WORD_W-1:0] result_o,
  output logic              align_err_o,
  output logic              bus_err_o
);

  logic              we_q, we_d;
  logic [REG_W-1:0]  dest_q, dest_d;
  logic [WORD_W-1:0] result_q, result_d;
  logic              align_err_q, bus_err_q;

  always_comb begin
    we_d     = 1'b0;
    dest_d   = dest_q;
    result_d = result_q;
    if (load_i) begin
      we_d     = we_i;
      dest_d   = dest_i;
      result_d = result_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q        <= 1'b0;
      dest_q      <= '0;
      result_q    <= '0;
      align_err_q <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      we_q        <= we_d;
      dest_q      <= dest_d;
      result_q    <= result_d;
      align_err_q <= align_err_i;
      bus_err_q   <= bus_err_i;
    end
  end

  assign we_o        = we_q;
  assign dest_o      = dest_q;
  assign result_o    = result_q;
  assign align_err_o = align_err_q;
  assign bus_err_o   = bus_err_q;

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage: stalls the pipeline while a data-memory access is in
// flight, aborts on timeout, flags misaligned accesses and feeds the W register.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int WORD_W  = WORD_WIDTH,
  parameter int REG_W   = REG_SIZE,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Regfile_weM,
  input  logic              DataMem_weM,
  input  logic              DataMem_reM,
  input  logic [REG_W-1:0]  wirteRegAddrM,
  input  logic [WORD_W-1:0] aluOutM,
  input  logic [WORD_W-1:0] writeDataM,
  output logic              stallM,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [WORD_W-1:0] dmem_addr,
  output logic [WORD_W-1:0] dmem_wdata,
  input  logic [WORD_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              Regfile_weW,
  output logic [REG_W-1:0]  wirteRegAddrW,
  output logic [WORD_W-1:0] resultW,
  output logic              alignErrW,
  output logic              busErrW
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              store_q, store_d;
  logic              rfwe_q, rfwe_d;
  logic [REG_W-1:0]  dest_q, dest_d;

  logic              mem_op, aligned, last_cycle, stall;
  logic              w_load, w_we, align_err, bus_err;
  logic [REG_W-1:0]  w_dest;
  logic [WORD_W-1:0] w_result;

  assign mem_op     = DataMem_weM | DataMem_reM;
  assign aligned    = (aluOutM[1:0] == 2'b00);
  assign last_cycle = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    store_d   = store_q;
    rfwe_d    = rfwe_q;
    dest_d    = dest_q;
    stall     = 1'b0;
    w_load    = 1'b0;
    w_we      = 1'b0;
    w_dest    = wirteRegAddrM;
    w_result  = aluOutM;
    align_err = 1'b0;
    bus_err   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!mem_op) begin
          w_load = 1'b1;
          w_we   = Regfile_weM;
        end else if (aligned) begin
          // A store wins when both strobes are set.
          stall   = 1'b1;
          addr_d  = aluOutM;
          wdata_d = writeDataM;
          store_d = DataMem_weM;
          rfwe_d  = Regfile_weM;
          dest_d  = wirteRegAddrM;
          cnt_d   = '0;
          state_d = BUSY;
        end else begin
          align_err = 1'b1;
        end
      end
      BUSY: begin
        if (dmem_ack) begin
          state_d = IDLE;
          if (!store_q) begin
            w_load   = 1'b1;
            w_we     = rfwe_q;
            w_dest   = dest_q;
            w_result = dmem_rdata;
          end
        end else if (last_cycle) begin
          bus_err = 1'b1;
          state_d = IDLE;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      store_q <= 1'b0;
      rfwe_q  <= 1'b0;
      dest_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      store_q <= store_d;
      rfwe_q  <= rfwe_d;
      dest_q  <= dest_d;
    end
  end

  // Reset masks the request and stall immediately so nothing upstream waits on an abandoned access.
  assign stallM     = stall & ~rst;
  assign dmem_req   = (state_q == BUSY) & ~rst;
  assign dmem_we    = dmem_req & store_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;

  mem_wb_reg #(
    .WORD_W (WORD_W),
    .REG_W  (REG_W)
  ) u_mem_wb_reg (
    .clk         (clk),
    .rst         (rst),
    .load_i      (w_load),
    .we_i        (w_we),
    .dest_i      (w_dest),
    .result_i    (w_result),
    .align_err_i (align_err),
    .bus_err_i   (bus_err),
    .we_o        (Regfile_weW),
    .dest_o      (wirteRegAddrW),
    .result_o    (resultW),
    .align_err_o (alignErrW),
    .bus_err_o   (busErrW)
  );

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench: directed scenarios plus random ops checked against a
// transaction-level model of the stage.
module tb_mem_access_stage;
  import mem_access_stage_pkg::*;

  localparam int WW = 32;
  localparam int RW = 5;
  localparam int TO = DEFAULT_TIMEOUT;

  logic          clk = 1'b0;
  logic          rst;
  logic          Regfile_weM, DataMem_weM, DataMem_reM;
  logic [RW-1:0] wirteRegAddrM;
  logic [WW-1:0] aluOutM, writeDataM;
  logic          stallM, dmem_req, dmem_we;
  logic [WW-1:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic          dmem_ack;
  logic          Regfile_weW;
  logic [RW-1:0] wirteRegAddrW;
  logic [WW-1:0] resultW;
  logic          alignErrW, busErrW;

  mem_access_stage #(.WORD_W(WW), .REG_W(RW), .TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .Regfile_weM   (Regfile_weM),
    .DataMem_weM   (DataMem_weM),
    .DataMem_reM   (DataMem_reM),
    .wirteRegAddrM (wirteRegAddrM),
    .aluOutM       (aluOutM),
    .writeDataM    (writeDataM),
    .stallM        (stallM),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_rdata    (dmem_rdata),
    .dmem_ack      (dmem_ack),
    .Regfile_weW   (Regfile_weW),
    .wirteRegAddrW (wirteRegAddrW),
    .resultW       (resultW),
    .alignErrW     (alignErrW),
    .busErrW       (busErrW)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model of the architecturally visible W destination/result.
  logic [RW-1:0] exp_dest;
  logic [WW-1:0] exp_res;
  bit            w_known;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Called just after an edge: checks W outputs against the model.
  task automatic check_w(input string tag, input bit we, input bit ae, input bit be);
    check({tag, "_weW"},   Regfile_weW, we);
    check({tag, "_alignErr"}, alignErrW, ae);
    check({tag, "_busErr"},   busErrW, be);
    if (w_known) begin
      check({tag, "_destW"},   wirteRegAddrW, exp_dest);
      check({tag, "_resultW"}, resultW, exp_res);
    end
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  // Presents one M-stage op and follows it to completion.
  // ack_at: BUSY cycle (1-based) on which ack is returned; > TO means never.
  task automatic run_op(input string tag, input bit rfwe, input bit rd, input bit wr,
                        input logic [RW-1:0] dest, input logic [WW-1:0] addr,
                        input logic [WW-1:0] wdata, input int ack_at,
                        input logic [WW-1:0] rdata);
    bit mem     = rd | wr;
    bit aligned = (addr[1:0] == 2'b00);
    bit done    = 1'b0;
    Regfile_weM   = rfwe;
    DataMem_reM   = rd;
    DataMem_weM   = wr;
    wirteRegAddrM = dest;
    aluOutM       = addr;
    writeDataM    = wdata;
    dmem_ack      = 1'($urandom_range(0, 1));
    dmem_rdata    = $urandom;
    @(negedge clk);
    check({tag, "_idle_stall"}, stallM, mem && aligned);
    check({tag, "_idle_req"}, dmem_req, 1'b0);
    next_edge();
    if (!mem) begin
      exp_dest = dest;
      exp_res  = addr;
      w_known  = 1'b1;
      check_w({tag, "_alu"}, rfwe, 1'b0, 1'b0);
    end else if (!aligned) begin
      check_w({tag, "_misalign"}, 1'b0, 1'b1, 1'b0);
    end else begin
      for (int k = 1; k <= TO && !done; k++) begin
        bit ack = (k == ack_at);
        dmem_ack   = ack;
        dmem_rdata = ack ? rdata : $urandom;
        @(negedge clk);
        check({tag, "_busy_req"}, dmem_req, 1'b1);
        check({tag, "_busy_addr"}, dmem_addr, addr);
        check({tag, "_busy_we"}, dmem_we, wr);
        if (wr) check({tag, "_busy_wdata"}, dmem_wdata, wdata);
        check({tag, "_busy_stall"}, stallM, !ack && (k != TO));
        check_w({tag, "_bubble"}, 1'b0, 1'b0, 1'b0);
        next_edge();
        if (ack) begin
          done = 1'b1;
          if (wr) begin
            check_w({tag, "_store_done"}, 1'b0, 1'b0, 1'b0);
            w_known = 1'b0;
          end else begin
            exp_dest = dest;
            exp_res  = rdata;
            w_known  = 1'b1;
            check_w({tag, "_load_done"}, rfwe, 1'b0, 1'b0);
          end
        end else if (k == TO) begin
          done = 1'b1;
          check_w({tag, "_timeout"}, 1'b0, 1'b0, 1'b1);
        end
      end
    end
    dmem_ack = 1'b0;
  endtask

  task automatic clear_inputs();
    Regfile_weM   = 1'b0;
    DataMem_weM   = 1'b0;
    DataMem_reM   = 1'b0;
    wirteRegAddrM = '0;
    aluOutM       = '0;
    writeDataM    = '0;
    dmem_ack      = 1'b0;
    dmem_rdata    = '0;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    // Mem op visible during reset: stall and request must stay low.
    DataMem_reM = 1'b1;
    @(negedge clk);
    check("rst_stall", stallM, 1'b0);
    check("rst_req", dmem_req, 1'b0);
    next_edge();
    clear_inputs();
    rst = 1'b0;
    exp_dest = '0;
    exp_res  = '0;
    w_known  = 1'b1;
    check_w("reset", 1'b0, 1'b0, 1'b0);

    // Directed scenarios.
    run_op("alu", 1'b1, 1'b0, 1'b0, 5'd3, 32'h1234, 32'h0, 0, 32'h0);
    run_op("load3", 1'b1, 1'b1, 1'b0, 5'd7, 32'h100, 32'h0, 3, 32'hDEADBEEF);
    run_op("store1", 1'b0, 1'b0, 1'b1, 5'd9, 32'h200, 32'hCAFE, 1, 32'h0);
    run_op("both", 1'b1, 1'b1, 1'b1, 5'd4, 32'h300, 32'h55AA, 2, 32'h0);
    run_op("timeout", 1'b1, 1'b1, 1'b0, 5'd5, 32'h400, 32'h0, TO + 1, 32'h0);
    run_op("after_to", 1'b1, 1'b0, 1'b0, 5'd6, 32'h77, 32'h0, 0, 32'h0);
    run_op("ack_last", 1'b1, 1'b1, 1'b0, 5'd8, 32'h404, 32'h0, TO, 32'h0BADF00D);
    run_op("misalign", 1'b1, 1'b1, 1'b0, 5'd2, 32'h102, 32'h0, 1, 32'h0);
    run_op("post_mis", 1'b0, 1'b0, 1'b0, 5'd1, 32'h88, 32'h0, 0, 32'h0);

    // Reset on the second BUSY cycle together with ack.
    Regfile_weM   = 1'b1;
    DataMem_reM   = 1'b1;
    wirteRegAddrM = 5'd12;
    aluOutM       = 32'h500;
    next_edge();
    dmem_ack = 1'b0;
    next_edge();
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h12345678;
    rst        = 1'b1;
    @(negedge clk);
    check("rstbusy_stall", stallM, 1'b0);
    check("rstbusy_req", dmem_req, 1'b0);
    next_edge();
    rst = 1'b0;
    clear_inputs();
    exp_dest = '0;
    exp_res  = '0;
    w_known  = 1'b1;
    check_w("rstbusy_w", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("rstbusy_req_after", dmem_req, 1'b0);
    check("rstbusy_stall_after", stallM, 1'b0);
    next_edge();

    // Random traffic.
    for (int i = 0; i < 200; i++) begin
      int kind = int'($urandom_range(0, 3));
      logic [WW-1:0] addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
      run_op("rnd", 1'($urandom_range(0, 1)), kind == 1 || kind == 3, kind >= 2,
             RW'($urandom), addr, $urandom, int'($urandom_range(1, TO + 2)), $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 The block SHALL use one clock and a synchronous active-high reset: the clock is `clk`, the reset is `rst`, and all state updates occur on the posedge of `clk`.
REQ-002 The block SHALL have these parameters:
- WORD_W, default 32, data/address width.
- REG_W, default 5, register-address width.
- TIMEOUT, default 16, the maximum number of BUSY cycles allowed before abort.
REQ-003 The block SHALL have these ports:
- clk  in  1  clock.
- rst  in  1  sync reset, active high.
- Regfile_weM  in  1  instruction writes the register file.
- DataMem_weM  in  1  store.
- DataMem_reM  in  1  load.
- wirteRegAddrM  in  REG_W  destination register.
- aluOutM  in  WORD_W  ALU result / memory address.
- writeDataM  in  WORD_W  store data.
- stallM  out  1  freezes the EX/MEM register and all upstream stages.
- dmem_req  out  1  memory request.
- dmem_we  out  1  write strobe.
- dmem_addr  out  WORD_W  word address.
- dmem_wdata  out  WORD_W  store data.
- dmem_rdata  in  WORD_W  load data.
- dmem_ack  in  1  access complete.
- Regfile_weW  out  1  writeback enable.
- wirteRegAddrW  out  REG_W  writeback register.
- resultW  out  WORD_W  writeback value.
- alignErrW  out  1  misaligned-access pulse.
- busErrW  out  1  timeout pulse.

Function
REQ-004 The block SHALL implement a 2-state FSM with states IDLE and BUSY.
REQ-005 A memory op SHALL be defined as (DataMem_weM | DataMem_reM); if both are high, the op SHALL be treated as a store.
REQ-006 For a non-memory op in IDLE, the block SHALL keep stallM=0 and, at the next edge, load W from M: Regfile_weW=Regfile_weM, wirteRegAddrW=wirteRegAddrM, resultW=aluOutM (1-cycle latency).
REQ-007 For an aligned memory op in IDLE (aluOutM[1:0]==0), the block SHALL assert stallM=1 combinationally and, at the edge, latch address, wdata, store flag, destination and write-enable, then enter BUSY.
REQ-008 In BUSY, the block SHALL drive dmem_req=1, with dmem_addr, dmem_wdata and dmem_we driven from the latched values and held stable until ack or abort.
REQ-009 In BUSY with dmem_ack=1, the block SHALL drive stallM=0 in that same cycle; at the edge it SHALL return to IDLE and load W as follows:
- load: resultW=dmem_rdata, Regfile_weW=latched write-enable.
- store: Regfile_weW=0.
REQ-010 With stallM=1, the W register SHALL load a bubble each cycle: Regfile_weW=0, with wirteRegAddrW and resultW holding their previous values.
REQ-011 The block SHALL keep a BUSY cycle counter that is cleared on entry to BUSY; when the counter equals TIMEOUT-1 and dmem_ack=0, the block SHALL abort:
- stallM=0 in that cycle.
- At the edge: busErrW=1 for one cycle, Regfile_weW=0, state→IDLE.
REQ-012 An ack arriving in the final counted cycle SHALL take precedence over the timeout, so the access completes normally.
REQ-013 For a misaligned memory op in IDLE (aluOutM[1:0]!=0), the block SHALL issue no request and keep stallM=0; at the edge it SHALL set alignErrW=1 for one cycle and Regfile_weW=0.
REQ-014 dmem_ack SHALL be ignored in IDLE.
REQ-015 alignErrW and busErrW SHALL be single-cycle pulses and SHALL otherwise be 0.
REQ-016 The minimum memory-op occupancy SHALL be 2 cycles (IDLE→BUSY with ack on the first BUSY cycle), and the maximum SHALL be TIMEOUT+1 cycles.
REQ-017 Outputs stallM, dmem_req, dmem_addr, dmem_wdata and dmem_we SHALL be functions of state and latched data only, plus (for stallM) the M inputs in IDLE and dmem_ack in BUSY.

Reset
REQ-018 On rst=1 at a clock edge, the block SHALL reset as follows:
- state=IDLE and counter=0.
- Regfile_weW=0, wirteRegAddrW=0, resultW=0.
- alignErrW=0, busErrW=0.
- All latched fields cleared.
REQ-019 Reset SHALL take priority over every other event, including a reset in BUSY coincident with dmem_ack.
REQ-020 While rst=1 and after reset, the block SHALL drive dmem_req=0 and stallM=0 until a new memory op is presented; any in-flight access SHALL be abandoned with no writeback.

Structure
REQ-021 The shared package SHALL hold:
- WORD_WIDTH, REG_SIZE, ZERO_WORD.
- The FSM state encoding (IDLE=0, BUSY=1).
- The default TIMEOUT.
REQ-022 The W pipeline register SHALL be a sub-module named mem_wb_reg, with a load/bubble select; the FSM, counter and latches SHALL remain in mem_access_stage.

Verification
REQ-023 The bench SHALL cover at least these directed scenarios:
- Reset then ALU op (Regfile_weM=1, addr=3, aluOutM=0x1234): next cycle Regfile_weW=1, wirteRegAddrW=3, resultW=0x1234, stallM=0 throughout.
- Load aluOutM=0x100, ack on the 3rd BUSY cycle with rdata=0xDEADBEEF: stallM high for 3 cycles, dmem_addr=0x100, dmem_we=0, then resultW=0xDEADBEEF and Regfile_weW=1 exactly once, with bubbles (Regfile_weW=0) during the stall.
- Store aluOutM=0x200, writeDataM=0xCAFE, ack on the 1st BUSY cycle: dmem_we=1, dmem_wdata=0xCAFE, total 2 cycles, Regfile_weW=0.
- Load with no ack: after TIMEOUT BUSY cycles, busErrW pulses once, Regfile_weW=0, stallM drops, and the next op proceeds; ack in the 16th cycle completes normally instead.
- Load at aluOutM=0x102: alignErrW pulse, dmem_req never asserted, no stall.
- rst asserted on the 2nd BUSY cycle with ack=1: no writeback, dmem_req=0 next cycle, and all W outputs are 0.
